// File: rtl/if_fetch_buffer_if.sv
// Fetch-queue bus between IF (push side), ID (pop side) and the redirect logic.
// The master modport is the IF/ID environment, the slave modport is the queue.
interface if_fetch_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            in_fault;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_fault;
    logic            flush;
    logic [CW-1:0]   count;
    logic            fault_lock;

    modport master (
        output in_valid, in_pc, in_instr, in_fault, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, out_fault, count, fault_lock
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_fault, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, out_fault, count, fault_lock
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// DEPTH-entry instruction fetch queue between IF and ID with flush and
// fetch-fault lock; a fault entry drains in order and blocks pushes until flush.
module if_fetch_buffer #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input logic           clk,
    input logic           rst,
    if_fetch_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic            lock_q;
    logic            push;
    logic            pop;

    // Ready is a function of registered state only, so IF never sees a path from out_ready.
    assign bus.in_ready  = (count_q < CW'(DEPTH)) & ~lock_q;
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign head          = mem[rd_ptr];
    assign bus.out_pc    = bus.out_valid ? head.pc    : '0;
    assign bus.out_instr = bus.out_valid ? head.instr : NOP_INSTR;
    assign bus.out_fault = bus.out_valid ? head.fault : 1'b0;
    assign bus.count      = count_q;
    assign bus.fault_lock = lock_q;

    // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            lock_q  <= 1'b0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (bus.in_fault) lock_q <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; a slot is only ever read after a push has written it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr, fault: bus.in_fault};
    end
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Scoreboard bench for if_fetch_buffer: three instances (DEPTH 4, 2, 8) share
// stimulus; a queue model predicts handshakes and the head of the selected one.
module tb_if_fetch_buffer;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_fault = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [31:0] in_pc = '0, in_instr = '0;

    int tests_run = 0;
    int tests_failed = 0;
    int sel = 0;
    int cur_depth = 4;
    int n_pop = 0;
    exp_t q[$];
    logic m_lock = 1'b0;

    logic        r_in_ready, r_out_valid, r_out_fault, r_fault_lock;
    logic [31:0] r_out_pc, r_out_instr;
    int          r_count;

    always #5 clk = ~clk;

    if_fetch_buffer_if #(.XLEN(32), .DEPTH(4)) bus4 ();
    if_fetch_buffer_if #(.XLEN(32), .DEPTH(2)) bus2 ();
    if_fetch_buffer_if #(.XLEN(32), .DEPTH(8)) bus8 ();

    if_fetch_buffer #(.XLEN(32), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    if_fetch_buffer #(.XLEN(32), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    if_fetch_buffer #(.XLEN(32), .DEPTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    assign bus4.in_valid = in_valid; assign bus4.in_pc = in_pc; assign bus4.in_instr = in_instr;
    assign bus4.in_fault = in_fault; assign bus4.out_ready = out_ready; assign bus4.flush = flush;
    assign bus2.in_valid = in_valid; assign bus2.in_pc = in_pc; assign bus2.in_instr = in_instr;
    assign bus2.in_fault = in_fault; assign bus2.out_ready = out_ready; assign bus2.flush = flush;
    assign bus8.in_valid = in_valid; assign bus8.in_pc = in_pc; assign bus8.in_instr = in_instr;
    assign bus8.in_fault = in_fault; assign bus8.out_ready = out_ready; assign bus8.flush = flush;

    always_comb begin
        case (sel)
            1: begin
                r_in_ready = bus2.in_ready; r_out_valid = bus2.out_valid; r_out_pc = bus2.out_pc;
                r_out_instr = bus2.out_instr; r_out_fault = bus2.out_fault;
                r_count = int'(bus2.count); r_fault_lock = bus2.fault_lock;
            end
            2: begin
                r_in_ready = bus8.in_ready; r_out_valid = bus8.out_valid; r_out_pc = bus8.out_pc;
                r_out_instr = bus8.out_instr; r_out_fault = bus8.out_fault;
                r_count = int'(bus8.count); r_fault_lock = bus8.fault_lock;
            end
            default: begin
                r_in_ready = bus4.in_ready; r_out_valid = bus4.out_valid; r_out_pc = bus4.out_pc;
                r_out_instr = bus4.out_instr; r_out_fault = bus4.out_fault;
                r_count = int'(bus4.count); r_fault_lock = bus4.fault_lock;
            end
        endcase
    end

    // One clock with the current inputs: compare handshakes and head against the
    // model, then advance the model exactly as the queue should after the edge.
    task automatic step();
        logic m_ready, do_push, do_pop;
        #1;
        m_ready = (q.size() < cur_depth) && !m_lock;
        do_push = in_valid && m_ready;
        do_pop  = out_ready && (q.size() != 0);
        tests_run++;
        if (r_in_ready !== m_ready) begin
            tests_failed++;
            $display("FAIL step_in_ready d=%0d: got %b want %b", cur_depth, r_in_ready, m_ready);
        end
        tests_run++;
        if (r_out_valid !== (q.size() != 0)) begin
            tests_failed++;
            $display("FAIL step_out_valid d=%0d: got %b want %b", cur_depth, r_out_valid, q.size() != 0);
        end
        tests_run++;
        if (r_fault_lock !== m_lock) begin
            tests_failed++;
            $display("FAIL step_fault_lock d=%0d: got %b want %b", cur_depth, r_fault_lock, m_lock);
        end
        tests_run++;
        if (q.size() != 0) begin
            if (r_out_pc !== q[0].pc || r_out_instr !== q[0].instr || r_out_fault !== q[0].fault) begin
                tests_failed++;
                $display("FAIL step_head d=%0d: got pc=%h instr=%h f=%b want pc=%h instr=%h f=%b",
                         cur_depth, r_out_pc, r_out_instr, r_out_fault, q[0].pc, q[0].instr, q[0].fault);
            end
        end else if (r_out_pc !== 32'h0 || r_out_instr !== NOP || r_out_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL step_empty_out d=%0d: got pc=%h instr=%h f=%b want pc=0 instr=%h f=0",
                     cur_depth, r_out_pc, r_out_instr, r_out_fault, NOP);
        end
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
            m_lock = 1'b0;
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (do_push) begin
                q.push_back('{pc: in_pc, instr: in_instr, fault: in_fault});
                if (in_fault) m_lock = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_fault = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic do_flush();
        drive_idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0; cur_depth = 4;
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (r_count !== 0 || r_out_valid !== 1'b0 || r_in_ready !== 1'b1 || r_fault_lock !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got count=%0d ov=%b ir=%b lock=%b want 0 0 1 0",
                     r_count, r_out_valid, r_in_ready, r_fault_lock);
        end
        tests_run++;
        if (r_out_instr !== NOP || r_out_pc !== 32'h0 || r_out_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got pc=%h instr=%h f=%b want 0 %h 0", r_out_pc, r_out_instr, r_out_fault, NOP);
        end
        q.delete(); m_lock = 1'b0;
        rst = 1'b0;
        in_pc = 32'h200; in_instr = 32'h0050_0093; in_fault = 1'b0;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (r_out_valid !== 1'b1 || r_out_pc !== 32'h200 || r_out_instr !== 32'h0050_0093) begin
            tests_failed++;
            $display("FAIL reset_first_push: got ov=%b pc=%h instr=%h want 1 00000200 00500093",
                     r_out_valid, r_out_pc, r_out_instr);
        end
        out_ready = 1'b1;
        step();
        drive_idle();
    endtask

    task automatic test_fill(input int s, input int depth);
        sel = s; cur_depth = depth;
        do_flush();
        for (int i = 0; i <= depth; i++) begin
            in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = $urandom; in_fault = 1'b0;
            step();
        end
        in_valid = 1'b0;
        tests_run++;
        if (r_count !== depth || r_in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_full d=%0d: got count=%0d ir=%b want %0d 0", depth, r_count, r_in_ready, depth);
        end
        out_ready = 1'b1;
        n_pop = 0;
        for (int i = 0; i < depth + 1; i++) step();
        tests_run++;
        if (n_pop !== depth || r_count !== 0 || r_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_drain d=%0d: got pops=%0d count=%0d ov=%b want %0d 0 0",
                     depth, n_pop, r_count, r_out_valid, depth);
        end
        drive_idle();
    endtask

    task automatic test_stream(input int s, input int depth);
        sel = s; cur_depth = depth;
        do_flush();
        n_pop = 0;
        in_valid = 1'b1; out_ready = 1'b1; in_fault = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_pc = 32'h1000 + 32'(4 * i); in_instr = $urandom;
            step();
            tests_run++;
            if (r_count !== 1) begin
                tests_failed++;
                $display("FAIL stream_count d=%0d cyc=%0d: got %0d want 1", depth, i, r_count);
            end
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if (n_pop !== 20 || q.size() !== 0) begin
            tests_failed++;
            $display("FAIL stream_total d=%0d: got pops=%0d left=%0d want 20 0", depth, n_pop, q.size());
        end
        drive_idle();
    endtask

    task automatic test_flush();
        sel = 0; cur_depth = 4;
        do_flush();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = 32'h30 + 32'(4 * i); in_instr = $urandom;
            step();
        end
        tests_run++;
        if (r_count !== 3) begin
            tests_failed++;
            $display("FAIL flush_pre_count: got %0d want 3", r_count);
        end
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h40; out_ready = 1'b1;
        step();
        drive_idle();
        tests_run++;
        if (r_count !== 0 || r_out_valid !== 1'b0 || r_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_collision: got count=%0d ov=%b ir=%b want 0 0 1", r_count, r_out_valid, r_in_ready);
        end
        in_valid = 1'b1; in_pc = 32'h50; in_instr = 32'h00A0_0113;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (r_out_valid !== 1'b1 || r_out_pc !== 32'h50) begin
            tests_failed++;
            $display("FAIL flush_post_push: got ov=%b pc=%h want 1 00000050", r_out_valid, r_out_pc);
        end
        out_ready = 1'b1;
        step();
        drive_idle();
    endtask

    task automatic test_fault_lock();
        sel = 0; cur_depth = 4;
        do_flush();
        in_valid = 1'b1; in_pc = 32'h8; in_instr = 32'h0000_0513; in_fault = 1'b0;
        step();
        in_pc = 32'hE; in_instr = 32'h0; in_fault = 1'b1;
        step();
        in_fault = 1'b0; in_pc = 32'h20; in_instr = 32'h1111_1111;
        tests_run++;
        if (r_fault_lock !== 1'b1 || r_in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_lock_rise: got lock=%b ir=%b want 1 0", r_fault_lock, r_in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if (r_fault_lock !== 1'b1 || r_count !== 0 || r_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_lock_hold: got lock=%b count=%0d ov=%b want 1 0 0", r_fault_lock, r_count, r_out_valid);
        end
        do_flush();
        tests_run++;
        if (r_fault_lock !== 1'b0 || r_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL fault_lock_clear: got lock=%b ir=%b want 0 1", r_fault_lock, r_in_ready);
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_fill(0, 4);
        test_stream(0, 4);
        test_flush();
        test_fault_lock();
        test_fill(1, 2);
        test_stream(1, 2);
        test_fill(2, 8);
        test_stream(2, 8);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/if_fetch_buffer.md
# if_fetch_buffer

Parametrised instruction fetch queue between the IF and ID stages, replacing the single IF/ID hand-off with a DEPTH-entry FIFO of {pc, instruction, fetch-fault} entries. IF pushes fetched words with a valid/ready handshake; ID pops them with its own valid/ready handshake. A flush discards all buffered entries on a taken branch, jump or exception redirect. A fetch fault (bad instruction address) is carried to ID in order and freezes further fetch until the redirect.

## Interface
Parameters:
- XLEN, 32, width of PC and instruction words
- DEPTH, 4, number of entries; power of two, ≥ 2
- NOP_INSTR, 32'h0000_0013, value driven on out_instr when the queue is empty

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  IF presents an entry
- in_ready  out  1  queue accepts an entry this cycle
- in_pc  in  XLEN  PC of fetched word
- in_instr  in  XLEN  fetched instruction
- in_fault  in  1  fetch address was misaligned or out of range (bad jump/branch target)
- out_valid  out  1  head entry valid for ID
- out_ready  in  1  ID consumes head entry
- out_pc  out  XLEN  head PC
- out_instr  out  XLEN  head instruction
- out_fault  out  1  head entry carries a fetch fault
- flush  in  1  discard all entries (branch taken, jump, trap redirect)
- count  out  $clog2(DEPTH+1)  number of valid entries
- fault_lock  out  1  fault entry accepted; pushes blocked until flush

## Operation
- Storage: circular array of DEPTH entries, read pointer rd_ptr and write pointer wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count tracks occupancy separately (no full/empty ambiguity).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count < DEPTH) & ~fault_lock. Depends only on registered state; no combinational path from out_ready or in_valid.
- out_valid = (count != 0). out_pc/out_instr/out_fault = entry at rd_ptr when out_valid; otherwise 0 / NOP_INSTR / 0.
- Push: write entry at wr_ptr, wr_ptr+1. Pop: rd_ptr+1. Both in one cycle: count unchanged.
- Push with in_fault=1 sets fault_lock. While locked, entries already queued (including the fault entry) continue to drain in order.
- Flush, highest priority: rd_ptr=wr_ptr=0, count=0, fault_lock=0. Any same-cycle push or pop is ignored (the pushed word is dropped, the pop has no effect; ID must also discard its captured word on flush).
- Full (count==DEPTH): in_ready=0 even when out_ready=1; a same-cycle pop frees a slot for the next cycle.
- Empty: out_valid=0; out_ready is ignored.
- Storage array is not reset; only pointers, count and fault_lock are reset.

## Timing
- Reset: in_ready=1, out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_fault=0, count=0, fault_lock=0 from the first edge with rst=1; rst overrides flush, push and pop.
- Push-to-out latency: 1 cycle (entry pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1). No same-cycle bypass.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Flush effect: out_valid=0 and in_ready=1 in the cycle after the flush edge; the first post-flush push appears on out_* one cycle later.
- fault_lock rises in the cycle after the faulting push; in_ready falls in that same cycle.

## Test plan
- Reset: hold rst=1 2 cycles with in_valid=1 → count=0, out_valid=0, out_instr=32'h0000_0013, in_ready=1; release, push pc=0x200 instr=0x00500093 → next cycle out_valid=1, out_pc=0x200, out_instr=0x00500093.
- Fill/backpressure: out_ready=0, push 5 entries pc=0x0,0x4,…,0x10 at DEPTH=4 → first 4 accepted, count=4, in_ready=0, 5th not accepted; then out_ready=1 → pops in order 0x0,0x4,0x8,0xC.
- Streaming with wrap: in_valid=out_ready=1 for 20 cycles, pc incrementing by 4 → every pc appears once, in order, count stays 1 after the first cycle, pointers wrap without loss.
- Flush collision: count=3, assert flush with in_valid=1 (pc=0x40) and out_ready=1 → next cycle count=0, out_valid=0; pc=0x40 never appears on out_pc.
- Fault lock: push pc=0x8 (ok), pc=0xE with in_fault=1 → fault_lock=1, in_ready=0; out sees 0x8 (fault 0) then 0xE (fault 1); further in_valid ignored until flush, after which fault_lock=0, in_ready=1.
- Parameter sweep: repeat fill and streaming with DEPTH=2 and DEPTH=8, XLEN=32 → identical ordering; count reaches exactly DEPTH.
